ultrasonido_filtro: RTL

//  Downstream consumer of the ultrasonic ranging stage. Captures each finished echo count, rejects out-of-range samples,
//  and keeps a 2^LOG2N-sample moving average. Drives a hysteretic obstacle flag and a sensor-fault flag (no new

---
 rtl/ultrasonido_filtro_if.sv | 32 +++
 rtl/ultrasonido_filtro.sv | 103 ++++++++++
 2 files changed

// File: rtl/ultrasonido_filtro_if.sv
// rtl/ultrasonido_filtro_if.sv - ranging-stage to filter link plus filter results toward the PIO interface
interface ultrasonido_filtro_if #(
  parameter int DATAWIDTH = 16
) ();
  logic [DATAWIDTH-1:0] Ultrasonido_Filtro_Conteo_In;
  logic                 Ultrasonido_Filtro_Trigger_In;
  logic [DATAWIDTH-1:0] Ultrasonido_Filtro_Promedio_Out;
  logic                 Ultrasonido_Filtro_Valido_Out;
  logic                 Ultrasonido_Filtro_Obstaculo_Out;
  logic                 Ultrasonido_Filtro_Falla_Out;
  logic [7:0]           Ultrasonido_Filtro_Rechazos_Out;

  modport master (
    output Ultrasonido_Filtro_Conteo_In,
    output Ultrasonido_Filtro_Trigger_In,
    input  Ultrasonido_Filtro_Promedio_Out,
    input  Ultrasonido_Filtro_Valido_Out,
    input  Ultrasonido_Filtro_Obstaculo_Out,
    input  Ultrasonido_Filtro_Falla_Out,
    input  Ultrasonido_Filtro_Rechazos_Out
  );

  modport slave (
    input  Ultrasonido_Filtro_Conteo_In,
    input  Ultrasonido_Filtro_Trigger_In,
    output Ultrasonido_Filtro_Promedio_Out,
    output Ultrasonido_Filtro_Valido_Out,
    output Ultrasonido_Filtro_Obstaculo_Out,
    output Ultrasonido_Filtro_Falla_Out,
    output Ultrasonido_Filtro_Rechazos_Out
  );
endinterface

// File: rtl/ultrasonido_filtro.sv
// rtl/ultrasonido_filtro.sv - range gate, moving average, hysteretic obstacle and timeout fault for echo counts
module ultrasonido_filtro #(
  parameter int                   DATAWIDTH  = 16,
  parameter int                   LOG2N      = 2,
  parameter logic [DATAWIDTH-1:0] MIN_VALID  = 16'h0010,
  parameter logic [DATAWIDTH-1:0] MAX_VALID  = 16'hF000,
  parameter logic [DATAWIDTH-1:0] UMBRAL_ON  = 16'h0400,
  parameter logic [DATAWIDTH-1:0] UMBRAL_OFF = 16'h0500,
  parameter logic [31:0]          TIMEOUT    = 32'd2000000
) (
  input  logic                Ultrasonido_Filtro_Clock,
  input  logic                Ultrasonido_Filtro_Reset_InLow,
  ultrasonido_filtro_if.slave bus
);
  localparam int              N         = 1 << LOG2N;
  localparam int              SW        = DATAWIDTH + LOG2N;
  localparam logic [LOG2N:0]  FILL_FULL = (LOG2N + 1)'(N);

  logic                 trig_d;
  logic                 rise;
  logic [DATAWIDTH-1:0] muestra;
  logic                 cap;
  logic                 upd;
  logic [DATAWIDTH-1:0] ventana [N];
  logic [SW-1:0]        suma;
  logic [LOG2N:0]       fill;
  logic [LOG2N-1:0]     wp;
  logic [31:0]          timer;
  logic [31:0]          timer_inc;
  logic                 fault_hit;
  logic                 accept;
  logic [DATAWIDTH-1:0] saliente;
  logic [DATAWIDTH-1:0] promedio_calc;

  always_comb begin
    rise          = bus.Ultrasonido_Filtro_Trigger_In & ~trig_d;
    timer_inc     = (timer >= TIMEOUT) ? TIMEOUT : timer + 32'd1;
    fault_hit     = ~rise && (timer_inc == TIMEOUT);
    accept        = (muestra >= MIN_VALID) && (muestra <= MAX_VALID);
    // Slots are only subtracted once the window is full; after a fault restart they hold stale data.
    saliente      = (fill == FILL_FULL) ? ventana[wp] : '0;
    promedio_calc = suma[SW-1:LOG2N];
  end

  always_ff @(posedge Ultrasonido_Filtro_Clock) begin
    if (!Ultrasonido_Filtro_Reset_InLow) begin
      trig_d  <= 1'b0;
      muestra <= '0;
      cap     <= 1'b0;
      upd     <= 1'b0;
      suma    <= '0;
      fill    <= '0;
      wp      <= '0;
      timer   <= '0;
      for (int i = 0; i < N; i++) ventana[i] <= '0;
      bus.Ultrasonido_Filtro_Promedio_Out  <= '0;
      bus.Ultrasonido_Filtro_Valido_Out    <= 1'b0;
      bus.Ultrasonido_Filtro_Obstaculo_Out <= 1'b0;
      bus.Ultrasonido_Filtro_Falla_Out     <= 1'b0;
      bus.Ultrasonido_Filtro_Rechazos_Out  <= '0;
    end else begin
      trig_d                            <= bus.Ultrasonido_Filtro_Trigger_In;
      cap                               <= rise;
      upd                               <= 1'b0;
      bus.Ultrasonido_Filtro_Valido_Out <= 1'b0;

      if (rise) begin
        muestra                          <= bus.Ultrasonido_Filtro_Conteo_In;
        timer                            <= '0;
        bus.Ultrasonido_Filtro_Falla_Out <= 1'b0;
      end else begin
        timer <= timer_inc;
        if (fault_hit) begin
          bus.Ultrasonido_Filtro_Falla_Out <= 1'b1;
          suma                             <= '0;
          fill                             <= '0;
          wp                               <= '0;
        end
      end

      if (cap) begin
        if (accept) begin
          suma        <= suma - SW'(saliente) + SW'(muestra);
          ventana[wp] <= muestra;
          wp          <= wp + 1'b1;
          fill        <= (fill == FILL_FULL) ? fill : fill + 1'b1;
          upd         <= 1'b1;
        end else if (bus.Ultrasonido_Filtro_Rechazos_Out != 8'hFF) begin
          bus.Ultrasonido_Filtro_Rechazos_Out <= bus.Ultrasonido_Filtro_Rechazos_Out + 8'd1;
        end
      end

      if (upd && fill == FILL_FULL) begin
        bus.Ultrasonido_Filtro_Promedio_Out <= promedio_calc;
        bus.Ultrasonido_Filtro_Valido_Out   <= 1'b1;
        if (promedio_calc < UMBRAL_ON)
          bus.Ultrasonido_Filtro_Obstaculo_Out <= 1'b1;
        else if (promedio_calc > UMBRAL_OFF)
          bus.Ultrasonido_Filtro_Obstaculo_Out <= 1'b0;
      end
    end
  end
endmodule
